// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: debounces two active-low buttons and sequences run/lap/clear.
// Latency: a held press changes state/outputs DEBOUNCE_CYCLES+4 edges after first sample.
// Backpressure: none; each button press yields at most one event, so nothing queues.

// Per-button synchronizer, debouncer and press-edge detector.
// Latency: press pulse DEBOUNCE_CYCLES+3 edges after the raw low is first sampled.
// Backpressure: none; a held button produces a single pulse.
module stopwatch_debounce #(
   parameter logic [15:0] DEBOUNCE_CYCLES = 16'd20
) (
   input  logic clk,
   input  logic rst,
   input  logic i_btn_n,
   output logic o_press
);

   logic        r_s1;
   logic        r_s2;
   logic        r_db;
   logic        r_db_q;
   logic        r_press;
   logic [15:0] r_cnt;
   logic        w_cnt_done;

   // The count only climbs while s2 disagrees with db, so reaching N-1 here
   // means this edge completes N consecutive disagreeing samples.
   assign w_cnt_done = (r_cnt == (DEBOUNCE_CYCLES - 16'd1));

   // Two-flop synchronizer; released (1) is the safe reset level.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1 <= 1'b1;
         r_s2 <= 1'b1;
      end else begin
         r_s1 <= i_btn_n;
         r_s2 <= r_s1;
      end
   end

   // Stability counter: accept the new level after enough consecutive samples.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_db  <= 1'b1;
         r_cnt <= 16'd0;
      end else if (r_s2 != r_db) begin
         if (w_cnt_done) begin
            r_db  <= r_s2;
            r_cnt <= 16'd0;
         end else begin
            r_cnt <= r_cnt + 16'd1;
         end
      end else begin
         r_cnt <= 16'd0;
      end
   end

   // One-cycle pulse the cycle after db falls; releases are ignored.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_db_q  <= 1'b1;
         r_press <= 1'b0;
      end else begin
         r_db_q  <= r_db;
         r_press <= r_db_q & ~r_db;
      end
   end

   assign o_press = r_press;

endmodule

// Top: two debounced buttons feeding the stopwatch mode FSM.
// Latency: state, run, freeze, clear update one edge after a press event.
// Backpressure: none; a lap event coinciding with a start event is dropped.
module stopwatch_ctrl #(
   parameter logic [15:0] DEBOUNCE_CYCLES = 16'd20
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_start,
   input  logic       btn_lap,
   output logic       run,
   output logic       clear,
   output logic       freeze,
   output logic [1:0] state
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_LAP   = 2'd3
   } state_t;

   state_t r_state;
   logic   r_run;
   logic   r_freeze;
   logic   r_clear;
   logic   w_start_evt;
   logic   w_lap_evt;

   stopwatch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_start (
      .clk     (clk),
      .rst     (rst),
      .i_btn_n (btn_start),
      .o_press (w_start_evt)
   );

   stopwatch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_lap (
      .clk     (clk),
      .rst     (rst),
      .i_btn_n (btn_lap),
      .o_press (w_lap_evt)
   );

   // Mode FSM with registered outputs; start has priority over lap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= ST_IDLE;
         r_run    <= 1'b0;
         r_freeze <= 1'b0;
         r_clear  <= 1'b0;
      end else begin
         r_clear <= 1'b0;
         if (w_start_evt) begin
            case (r_state)
               ST_IDLE: begin
                  r_state  <= ST_RUN;
                  r_run    <= 1'b1;
                  r_freeze <= 1'b0;
               end
               ST_RUN: begin
                  r_state  <= ST_PAUSE;
                  r_run    <= 1'b0;
                  r_freeze <= 1'b0;
               end
               ST_PAUSE: begin
                  r_state  <= ST_RUN;
                  r_run    <= 1'b1;
                  r_freeze <= 1'b0;
               end
               default: begin
                  r_state  <= ST_PAUSE;
                  r_run    <= 1'b0;
                  r_freeze <= 1'b0;
               end
            endcase
         end else if (w_lap_evt) begin
            case (r_state)
               ST_IDLE: begin
                  r_state  <= ST_IDLE;
                  r_run    <= 1'b0;
                  r_freeze <= 1'b0;
                  r_clear  <= 1'b1;
               end
               ST_RUN: begin
                  r_state  <= ST_LAP;
                  r_run    <= 1'b1;
                  r_freeze <= 1'b1;
               end
               ST_PAUSE: begin
                  r_state  <= ST_IDLE;
                  r_run    <= 1'b0;
                  r_freeze <= 1'b0;
                  r_clear  <= 1'b1;
               end
               default: begin
                  r_state  <= ST_RUN;
                  r_run    <= 1'b1;
                  r_freeze <= 1'b0;
               end
            endcase
         end
      end
   end

   assign run    = r_run;
   assign freeze = r_freeze;
   assign clear  = r_clear;
   assign state  = r_state;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with DEBOUNCE_CYCLES = 4.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
// Edge numbering: the first rising edge after an input change is edge 1.
module tb_stopwatch_ctrl;

   logic       clk;
   logic       rst;
   logic       btn_start;
   logic       btn_lap;
   logic       run;
   logic       clear;
   logic       freeze;
   logic [1:0] state;

   int n_total;
   int n_bad;

   stopwatch_ctrl #(.DEBOUNCE_CYCLES(16'd4)) dut (
      .clk       (clk),
      .rst       (rst),
      .btn_start (btn_start),
      .btn_lap   (btn_lap),
      .run       (run),
      .clear     (clear),
      .freeze    (freeze),
      .state     (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Hold a button long enough to act (8 edges), then release and let it settle.
   task automatic press_btn(input bit lap);
      if (lap) btn_lap = 1'b0;
      else     btn_start = 1'b0;
      repeat (8) tick();
      btn_start = 1'b1;
      btn_lap   = 1'b1;
      repeat (8) tick();
   endtask

   initial begin
      n_total   = 0;
      n_bad     = 0;
      rst       = 1'b1;
      btn_start = 1'b1;
      btn_lap   = 1'b1;
      repeat (3) tick();
      check("rst_state", 16'(state), 16'd0);
      check("rst_run", 16'(run), 16'd0);
      check("rst_freeze", 16'(freeze), 16'd0);
      check("rst_clear", 16'(clear), 16'd0);
      rst = 1'b0;
      repeat (2) tick();

      // Bounce: 3 low / 1 high, five times, never long enough to debounce.
      for (int r = 0; r < 5; r++) begin
         btn_start = 1'b0;
         repeat (3) begin
            tick();
            check("bounce_state", 16'(state), 16'd0);
         end
         btn_start = 1'b1;
         tick();
         check("bounce_state", 16'(state), 16'd0);
      end
      repeat (10) begin
         tick();
         check("bounce_settle_state", 16'(state), 16'd0);
      end
      check("bounce_run", 16'(run), 16'd0);

      // Held start: run rises exactly at edge 8, then nothing more.
      btn_start = 1'b0;
      for (int e = 1; e <= 7; e++) begin
         tick();
         check("start_run_early", 16'(run), 16'd0);
         check("start_state_early", 16'(state), 16'd0);
      end
      tick();
      check("start_run_e8", 16'(run), 16'd1);
      check("start_state_e8", 16'(state), 16'd1);
      repeat (50) begin
         tick();
         check("start_hold_state", 16'(state), 16'd1);
      end
      btn_start = 1'b1;
      repeat (10) tick();
      check("start_release_state", 16'(state), 16'd1);
      check("start_release_run", 16'(run), 16'd1);

      // RUNNING -> LAP -> RUNNING -> PAUSED
      press_btn(1'b1);
      check("lap1_state", 16'(state), 16'd3);
      check("lap1_run", 16'(run), 16'd1);
      check("lap1_freeze", 16'(freeze), 16'd1);
      press_btn(1'b1);
      check("lap2_state", 16'(state), 16'd1);
      check("lap2_run", 16'(run), 16'd1);
      check("lap2_freeze", 16'(freeze), 16'd0);
      press_btn(1'b0);
      check("pause_state", 16'(state), 16'd2);
      check("pause_run", 16'(run), 16'd0);
      check("pause_freeze", 16'(freeze), 16'd0);

      // PAUSED --lap--> IDLE with one clear pulse, then IDLE --lap--> IDLE with clear.
      for (int k = 0; k < 2; k++) begin
         btn_lap = 1'b0;
         repeat (7) tick();
         check("clr_pre_clear", 16'(clear), 16'd0);
         check("clr_pre_state", 16'(state), (k == 0) ? 16'd2 : 16'd0);
         tick();
         check("clr_pulse", 16'(clear), 16'd1);
         check("clr_state", 16'(state), 16'd0);
         check("clr_run", 16'(run), 16'd0);
         tick();
         check("clr_after", 16'(clear), 16'd0);
         repeat (3) begin
            tick();
            check("clr_after_hold", 16'(clear), 16'd0);
         end
         btn_lap = 1'b1;
         repeat (8) tick();
         check("clr_settle_state", 16'(state), 16'd0);
      end

      // Coincident start and lap from IDLE: start wins, lap is dropped.
      btn_start = 1'b0;
      btn_lap   = 1'b0;
      repeat (8) tick();
      check("both_state", 16'(state), 16'd1);
      check("both_clear", 16'(clear), 16'd0);
      check("both_freeze", 16'(freeze), 16'd0);
      btn_start = 1'b1;
      btn_lap   = 1'b1;
      repeat (8) tick();
      check("both_settle_state", 16'(state), 16'd1);
      check("both_settle_freeze", 16'(freeze), 16'd0);

      // Reset during LAP with start half-debounced; held start re-debounces fully.
      press_btn(1'b1);
      check("pre_rst_state", 16'(state), 16'd3);
      btn_start = 1'b0;
      repeat (3) tick();
      rst = 1'b1;
      #1;
      check("mid_rst_state", 16'(state), 16'd0);
      check("mid_rst_run", 16'(run), 16'd0);
      check("mid_rst_freeze", 16'(freeze), 16'd0);
      check("mid_rst_clear", 16'(clear), 16'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int e = 1; e <= 7; e++) begin
         tick();
         check("post_rst_run_early", 16'(run), 16'd0);
      end
      tick();
      check("post_rst_run_e8", 16'(run), 16'd1);
      check("post_rst_state_e8", 16'(state), 16'd1);
      repeat (20) begin
         tick();
         check("post_rst_hold_state", 16'(state), 16'd1);
      end
      btn_start = 1'b1;
      repeat (10) tick();
      check("post_rst_final_state", 16'(state), 16'd1);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
